regfile_writeback_queue: RTL and testbench
==========================================

// Module: regfile_writeback_queue
// PURPOSE
//  Writer end of the register file write port (address/WriteData/WriteEnable). Collects results
//  from ALU and LSU via valid/ready, arbitrates round-robin, buffers them in an in-order FIFO,
//  and drains one write per cycle into the register file unless stalled.
//  Sits between the execute/memory stages and Register_File.
// PARAMETERS
//  BITSIZE  32  data width of a result and of WriteData
//  REGSIZE  32  number of architectural registers; rd width = $clog2(REGSIZE)
//  DEPTH    4   FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1                    clock; all state updates on posedge
//  rst          in   1                    synchronous, active-high reset
//  alu_valid    in   1                    ALU result valid
//  alu_ready    out  1                    ALU result accepted this cycle when valid&ready
//  alu_rd       in   $clog2(REGSIZE)      ALU destination register
//  alu_data     in   BITSIZE              ALU result
//  lsu_valid    in   1                    LSU result valid
//  lsu_ready    out  1                    LSU result accepted when valid&ready
//  lsu_rd       in   $clog2(REGSIZE)      LSU destination register
//  lsu_data     in   BITSIZE              LSU load data
//  wb_stall     in   1                    hold write port (no dequeue this cycle)
//  address      out  $clog2(REGSIZE)      register file write address (FIFO head rd)
//  WriteData    out  BITSIZE              register file write data (FIFO head data)
//  WriteEnable  out  1                    = !empty & !wb_stall
//  ReadSelect1  in   $clog2(REGSIZE)      bypass lookup 1 (used only with WB_BYPASS_EN)
//  ReadSelect2  in   $clog2(REGSIZE)      bypass lookup 2 (used only with WB_BYPASS_EN)
//  fwd1_hit     out  1                    ReadSelect1 matches a queued entry
//  fwd1_data    out  BITSIZE              youngest queued data for ReadSelect1
//  fwd2_hit     out  1                    ReadSelect2 matches a queued entry
//  fwd2_data    out  BITSIZE              youngest queued data for ReadSelect2
//  count        out  $clog2(DEPTH+1)      occupied entries
//  full         out  1                    count == DEPTH
//  empty        out  1                    count == 0
// BEHAVIOUR
//  - Reset: pointers=0, count=0, rr=0 (ALU preferred); empty=1, full=0, WriteEnable=0,
//    address=0, WriteData=0, fwd*_hit=0, fwd*_data=0. Reset mid-operation discards all entries.
//  - Outputs address/WriteData are the head entry when !empty, else all zeros.
//  - Arbitration: grant ALU if alu_valid & (!lsu_valid | rr==0); else grant LSU if lsu_valid.
//    alu_ready = !full & grant_alu; lsu_ready = !full & grant_lsu; ungranted ready = 0.
//    After every accepted transfer rr points to the other source (rr<=1 after ALU, 0 after LSU).
//  - ready is conservative: full blocks acceptance even if a dequeue occurs same cycle.
//  - Enqueue on accept: {rd,data} written at wr_ptr, wr_ptr++ (mod DEPTH), count++.
//    rd==0: handshake completes, rr updates, nothing enqueued, count unchanged.
//  - Dequeue when WriteEnable: rd_ptr++ (mod DEPTH), count--. Simultaneous enqueue+dequeue:
//    count unchanged, both pointers advance.
//  - Latency: accepted at edge N -> WriteEnable/address/WriteData valid in cycle N+1
//    (if queue was empty and wb_stall=0); register file updates at edge ending N+1.
//  - Order: writes drain strictly in acceptance order; two writes to same rd both reach the file.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH nor goes below 0.
// CONFIGURATION
//  WB_BYPASS_EN defined: fwdN_hit=1 when some valid entry has rd==ReadSelectN and ReadSelectN!=0;
//    fwdN_data = data of youngest such entry (nearest to wr_ptr). Combinational from queue state;
//    excludes the entry being accepted this cycle. No match or x0: hit=0, data=0.
//  WB_BYPASS_EN undefined: fwd1_hit/fwd2_hit/fwd1_data/fwd2_data tied to 0; ReadSelect* unused.
// TESTING
//  1. Reset then ALU valid rd=5 data=0xDEADBEEF -> next cycle WriteEnable=1 address=5, then empty=1.
//  2. ALU and LSU valid every cycle, wb_stall=0 -> grants alternate ALU,LSU,ALU,...; count<=1.
//  3. wb_stall=1, push 4 ALU writes -> full=1, count=4, alu_ready=0; release stall -> 4 writes in order.
//  4. ALU write rd=0 data=0x1234 -> alu_ready=1, count stays 0, WriteEnable never asserts.
//  5. WB_BYPASS_EN, stall, queue rd=7:0x11 then rd=7:0x22, ReadSelect1=7 -> fwd1_hit=1 fwd1_data=0x22.
//  6. rst asserted with count=3 -> next cycle count=0, empty=1, WriteEnable=0, rr=0.

Source files
------------

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - round-robin ALU/LSU writeback queue feeding the register file write port (optional WB_BYPASS_EN forwarding)
module regfile_writeback_queue #(
    parameter int BITSIZE = 32,
    parameter int REGSIZE = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [$clog2(REGSIZE)-1:0] alu_rd,
    input  logic [BITSIZE-1:0]         alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [$clog2(REGSIZE)-1:0] lsu_rd,
    input  logic [BITSIZE-1:0]         lsu_data,
    input  logic                       wb_stall,
    output logic [$clog2(REGSIZE)-1:0] address,
    output logic [BITSIZE-1:0]         WriteData,
    output logic                       WriteEnable,
    input  logic [$clog2(REGSIZE)-1:0] ReadSelect1,
    input  logic [$clog2(REGSIZE)-1:0] ReadSelect2,
    output logic                       fwd1_hit,
    output logic [BITSIZE-1:0]         fwd1_data,
    output logic                       fwd2_hit,
    output logic [BITSIZE-1:0]         fwd2_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int RW = $clog2(REGSIZE);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [RW-1:0]      rd_mem_q   [DEPTH];
    logic [BITSIZE-1:0] data_mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               rr_q, rr_d;

    logic               grant_alu, grant_lsu;
    logic               accept, push, pop;
    logic [RW-1:0]      in_rd;
    logic [BITSIZE-1:0] in_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Arbitration and handshake; rd==0 results complete the handshake but are dropped
    always_comb begin
        grant_alu   = alu_valid & (~lsu_valid | ~rr_q);
        grant_lsu   = ~grant_alu & lsu_valid;
        alu_ready   = ~full & grant_alu;
        lsu_ready   = ~full & grant_lsu;
        accept      = (alu_valid & alu_ready) | (lsu_valid & lsu_ready);
        in_rd       = grant_alu ? alu_rd : lsu_rd;
        in_data     = grant_alu ? alu_data : lsu_data;
        push        = accept & (in_rd != '0);
        WriteEnable = ~empty & ~wb_stall;
        pop         = WriteEnable;
    end

    // Next-state for pointers, occupancy and round-robin token
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        rr_d = accept ? grant_alu : rr_q;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // Queue storage; contents beyond count are don't-care so no reset needed
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            rd_mem_q[wr_ptr_q]   <= in_rd;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Head of queue drives the write port, zeroed when empty
    always_comb begin
        address   = empty ? '0 : rd_mem_q[rd_ptr_q];
        WriteData = empty ? '0 : data_mem_q[rd_ptr_q];
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                if ((ReadSelect1 != '0) && (rd_mem_q[rd_ptr_q + PW'(i)] == ReadSelect1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_mem_q[rd_ptr_q + PW'(i)];
                end
                if ((ReadSelect2 != '0) && (rd_mem_q[rd_ptr_q + PW'(i)] == ReadSelect2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_mem_q[rd_ptr_q + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_read_select;
    assign unused_read_select = ^{ReadSelect1, ReadSelect2};

    // Forwarding disabled: lookup outputs held at zero
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed vector bench for regfile_writeback_queue
module tb_regfile_writeback_queue;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, address, ReadSelect1, ReadSelect2;
    logic [31:0] alu_data, lsu_data, WriteData, fwd1_data, fwd2_data;
    logic        wb_stall, WriteEnable, fwd1_hit, fwd2_hit, full, empty;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.BITSIZE(32), .REGSIZE(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .address(address), .WriteData(WriteData), .WriteEnable(WriteEnable),
        .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count), .full(full), .empty(empty)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        stall;
        logic        ar;
        logic        lr;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [2:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                                input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldat, input logic st, input logic ar,
                                input logic lr, input logic we, input logic [4:0] addr,
                                input logic [31:0] wd, input logic [2:0] cnt);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd;
        v.ldat = ldat; v.stall = st; v.ar = ar; v.lr = lr; v.we = we; v.addr = addr;
        v.wd = wd; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_fwd(input string name, input logic h1, input logic [31:0] d1,
                             input logic h2, input logic [31:0] d2);
        checks++;
        if (fwd1_hit !== h1 || fwd1_data !== d1 || fwd2_hit !== h2 || fwd2_data !== d2) begin
            errors++;
            $display("FAIL %s: got hit1=%0b d1=%h hit2=%0b d2=%h, want hit1=%0b d1=%h hit2=%0b d2=%h",
                     name, fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, h1, d1, h2, d2);
        end
    endtask

    task automatic check_wb(input string name, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic [2:0] c);
        checks++;
        if (WriteEnable !== we || address !== a || WriteData !== d || count !== c) begin
            errors++;
            $display("FAIL %s: got we=%0b addr=%0d data=%h cnt=%0d, want we=%0b addr=%0d data=%h cnt=%0d",
                     name, WriteEnable, address, WriteData, count, we, a, d, c);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    vec_t vecs [26];

    initial begin
        logic xf, xe;
        //            rst av ard  adat          lv lrd ldat      st  ar lr we addr wd            cnt
        vecs[0]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 0, 0,  32'h0,         0);
        vecs[1]  = mk(0, 1, 5,  32'hDEADBEEF,  0, 0,  32'h0,    0,  1, 0, 0, 0,  32'h0,         0);
        vecs[2]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 5,  32'hDEADBEEF,  1);
        vecs[3]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 0, 0,  32'h0,         0);
        vecs[4]  = mk(0, 1, 1,  32'hA1,        1, 2,  32'hB2,   0,  0, 1, 0, 0,  32'h0,         0);
        vecs[5]  = mk(0, 1, 3,  32'hA3,        1, 4,  32'hB4,   0,  1, 0, 1, 2,  32'hB2,        1);
        vecs[6]  = mk(0, 1, 5,  32'hA5,        1, 6,  32'hB6,   0,  0, 1, 1, 3,  32'hA3,        1);
        vecs[7]  = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 6,  32'hB6,        1);
        vecs[8]  = mk(0, 1, 8,  32'h100,       0, 0,  32'h0,    1,  1, 0, 0, 0,  32'h0,         0);
        vecs[9]  = mk(0, 1, 9,  32'h101,       0, 0,  32'h0,    1,  1, 0, 0, 8,  32'h100,       1);
        vecs[10] = mk(0, 1, 10, 32'h102,       0, 0,  32'h0,    1,  1, 0, 0, 8,  32'h100,       2);
        vecs[11] = mk(0, 1, 11, 32'h103,       0, 0,  32'h0,    1,  1, 0, 0, 8,  32'h100,       3);
        vecs[12] = mk(0, 1, 12, 32'h104,       0, 0,  32'h0,    1,  0, 0, 0, 8,  32'h100,       4);
        vecs[13] = mk(0, 1, 12, 32'h104,       0, 0,  32'h0,    0,  0, 0, 1, 8,  32'h100,       4);
        vecs[14] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 9,  32'h101,       3);
        vecs[15] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 10, 32'h102,       2);
        vecs[16] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 11, 32'h103,       1);
        vecs[17] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 0, 0,  32'h0,         0);
        vecs[18] = mk(0, 1, 0,  32'h1234,      0, 0,  32'h0,    0,  1, 0, 0, 0,  32'h0,         0);
        vecs[19] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 0, 0,  32'h0,         0);
        vecs[20] = mk(0, 0, 0,  32'h0,         1, 13, 32'h200,  1,  0, 1, 0, 0,  32'h0,         0);
        vecs[21] = mk(0, 1, 14, 32'h300,       1, 15, 32'h400,  1,  1, 0, 0, 13, 32'h200,       1);
        vecs[22] = mk(0, 1, 16, 32'h500,       0, 0,  32'h0,    1,  1, 0, 0, 13, 32'h200,       2);
        vecs[23] = mk(1, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 13, 32'h200,       3);
        vecs[24] = mk(0, 1, 18, 32'h700,       1, 19, 32'h800,  0,  1, 0, 0, 0,  32'h0,         0);
        vecs[25] = mk(0, 0, 0,  32'h0,         0, 0,  32'h0,    0,  0, 0, 1, 18, 32'h700,       1);

        rst = 1; wb_stall = 0; ReadSelect1 = 0; ReadSelect2 = 0;
        idle_inputs();
        repeat (2) @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            rst = vecs[i].rst; wb_stall = vecs[i].stall;
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldat;
            #1;
            xf = (vecs[i].cnt == 3'd4);
            xe = (vecs[i].cnt == 3'd0);
            checks++;
            if (alu_ready !== vecs[i].ar || lsu_ready !== vecs[i].lr || WriteEnable !== vecs[i].we ||
                address !== vecs[i].addr || WriteData !== vecs[i].wd || count !== vecs[i].cnt ||
                full !== xf || empty !== xe || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 ||
                fwd1_data !== 32'h0 || fwd2_data !== 32'h0) begin
                errors++;
                $display("FAIL vec%0d: got ar=%0b lr=%0b we=%0b addr=%0d wd=%h cnt=%0d full=%0b empty=%0b f1=%0b f2=%0b, want ar=%0b lr=%0b we=%0b addr=%0d wd=%h cnt=%0d full=%0b empty=%0b f1=0 f2=0",
                         i, alu_ready, lsu_ready, WriteEnable, address, WriteData, count, full, empty,
                         fwd1_hit, fwd2_hit, vecs[i].ar, vecs[i].lr, vecs[i].we, vecs[i].addr,
                         vecs[i].wd, vecs[i].cnt, xf, xe);
            end
            @(negedge clk);
        end

        // Forwarding: youngest match wins, in-flight accept excluded, x0 never hits
        wb_stall = 1; ReadSelect1 = 7; ReadSelect2 = 3;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h11;
        #1 check_fwd("fwd_empty", 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        alu_rd = 7; alu_data = 32'h22;
        #1 check_fwd("fwd_one", BYP, BYP ? 32'h11 : 32'h0, 0, 32'h0);
        @(negedge clk);
        alu_rd = 3; alu_data = 32'h33;
        #1 check_fwd("fwd_youngest", BYP, BYP ? 32'h22 : 32'h0, 0, 32'h0);
        @(negedge clk);
        alu_rd = 9; alu_data = 32'h99; ReadSelect2 = 9;
        #1 check_fwd("fwd_excl_accept", BYP, BYP ? 32'h22 : 32'h0, 0, 32'h0);
        @(negedge clk);
        idle_inputs(); ReadSelect1 = 0; ReadSelect2 = 3;
        #1 check_fwd("fwd_x0_full", 0, 32'h0, BYP, BYP ? 32'h33 : 32'h0);
        ReadSelect2 = 9;
        #1 check_fwd("fwd_newest", 0, 32'h0, BYP, BYP ? 32'h99 : 32'h0);
        check_wb("full_stalled", 0, 7, 32'h11, 4);

        // Release stall: entries drain in acceptance order, one per cycle
        wb_stall = 0;
        #1 check_wb("drain0", 1, 7, 32'h11, 4);
        @(negedge clk); #1 check_wb("drain1", 1, 7, 32'h22, 3);
        @(negedge clk); #1 check_wb("drain2", 1, 3, 32'h33, 2);
        @(negedge clk); #1 check_wb("drain3", 1, 9, 32'h99, 1);
        @(negedge clk); #1 check_wb("drained", 0, 0, 32'h0, 0);
        check_fwd("fwd_after_drain", 0, 32'h0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
